mux_scan: RTL and testbench

Parametrised, registered N:1 multiplexer with W-bit channels, and the successor to the fixed 5:1 single-bit select mux. It has two modes:
- **Manual:** the caller drives the select.
- **Auto-scan:** an internal sequencer visits each enabled channel for DWELL cycles, skipping masked channels.

It sits between a bank of sensor/data channels and a single downstream consumer. The output is registered and qualified by `valid`.

---
 rtl/mux_scan.sv | 236 +++++++++++++++++++++++
 tb/tb_mux_scan.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// mux_scan
//
// Registered N:1 multiplexer with W-bit channels. Two ways to pick the channel:
//   - manual:    the caller drives the select `s`
//   - auto-scan: an internal sequencer visits each enabled channel for DWELL
//                cycles, skipping channels whose en_mask bit is clear
//
// Ports
//   clk      in   1     rising-edge clock
//   reset_n  in   1     synchronous, active-low reset
//   d        in   N*W   packed channel data, channel k at d[k*W +: W]
//   s        in   SW    manual select
//   mode     in   1     0 = manual, 1 = auto-scan
//   en_mask  in   N     bit k = 1 enables channel k
//   y        out  W     registered selected data
//   cur      out  SW    channel index that y carries
//   valid    out  1     y holds data from an enabled, in-range channel
//   wrap     out  1     one-cycle pulse when the scan returns to a lower or
//                       equal index
//
// All four outputs come from a single register stage, so they always describe
// the same edge. No input reaches an output combinationally.
// -----------------------------------------------------------------------------
module mux_scan #(
    parameter int N     = 5,
    parameter int W     = 1,
    parameter int DWELL = 4,
    parameter int SW    = $clog2(N)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N*W-1:0]   d,
    input  logic [SW-1:0]    s,
    input  logic             mode,
    input  logic [N-1:0]     en_mask,
    output logic [W-1:0]     y,
    output logic [SW-1:0]    cur,
    output logic             valid,
    output logic             wrap
);

    localparam logic [1:0] ST_MANUAL = 2'd0;
    localparam logic [1:0] ST_SCAN   = 2'd1;
    localparam logic [1:0] ST_IDLE   = 2'd2;

    localparam int             DW         = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0]  DWELL_LAST = DW'(DWELL - 1);

    // True when idx names an existing channel.
    function automatic logic in_range(input logic [SW-1:0] idx);
        return int'(idx) < N;
    endfunction

    // Mask lookup by compare rather than variable indexing, so an index that
    // is >= N (possible on the manual select) reads as disabled.
    function automatic logic ch_enabled(input logic [N-1:0]  mask,
                                        input logic [SW-1:0] idx);
        logic en;
        en = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (int'(idx) == k) en = mask[k];
        end
        return en;
    endfunction

    // Channel data by compare; out-of-range indices give zero.
    function automatic logic [W-1:0] ch_data(input logic [N*W-1:0] data,
                                             input logic [SW-1:0]  idx);
        logic [W-1:0] v;
        v = '0;
        for (int k = 0; k < N; k++) begin
            if (int'(idx) == k) v = data[k*W +: W];
        end
        return v;
    endfunction

    // Lowest enabled channel; descending loop so the lowest index wins.
    function automatic logic [SW-1:0] lowest_en(input logic [N-1:0] mask);
        logic [SW-1:0] idx;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (mask[k]) idx = SW'(k);
        end
        return idx;
    endfunction

    // Next enabled channel strictly after idx, circularly. Offset N lands back
    // on idx itself, which is how a lone enabled channel keeps being chosen.
    function automatic logic [SW-1:0] next_en(input logic [N-1:0]  mask,
                                              input logic [SW-1:0] idx);
        logic [SW-1:0] nxt;
        logic          found;
        int            j;
        nxt   = idx;
        found = 1'b0;
        for (int off = 1; off <= N; off++) begin
            j = int'(idx) + off;
            if (j >= N) j = j - N;
            if (j >= N) j = j - N;
            if (!found && (j < N) && ch_enabled(mask, SW'(j))) begin
                nxt   = SW'(j);
                found = 1'b1;
            end
        end
        return nxt;
    endfunction

    // Registered state and outputs
    logic [1:0]     state_p1;
    logic [DW-1:0]  cnt_p1;
    logic [W-1:0]   y_p1;
    logic [SW-1:0]  cur_p1;
    logic           vld_p1;
    logic           wrap_p1;

    // Next-edge values
    logic [1:0]     state_p0;
    logic [DW-1:0]  cnt_p0;
    logic [W-1:0]   y_p0;
    logic [SW-1:0]  cur_p0;
    logic           vld_p0;
    logic           wrap_p0;

    logic           man_ok;
    logic [W-1:0]   man_y;
    logic           any_en;
    logic           cur_en;
    logic [SW-1:0]  low_idx;
    logic [SW-1:0]  nxt_idx;
    logic [W-1:0]   low_data;
    logic [W-1:0]   nxt_data;
    logic [W-1:0]   cur_data;

    assign man_ok   = in_range(s) && ch_enabled(en_mask, s);
    assign man_y    = man_ok ? ch_data(d, s) : '0;
    assign any_en   = |en_mask;
    assign cur_en   = ch_enabled(en_mask, cur_p1);
    assign low_idx  = lowest_en(en_mask);
    assign nxt_idx  = next_en(en_mask, cur_p1);
    assign low_data = ch_data(d, low_idx);
    assign nxt_data = ch_data(d, nxt_idx);
    assign cur_data = ch_data(d, cur_p1);

    // p0: next-state decision
    always_comb begin
        state_p0 = state_p1;
        cnt_p0   = cnt_p1;
        y_p0     = y_p1;
        cur_p0   = cur_p1;
        vld_p0   = vld_p1;
        wrap_p0  = 1'b0;

        case (state_p1)
            ST_SCAN: begin
                if (!mode) begin
                    // Leaving scan: the manual rules already apply on this edge.
                    state_p0 = ST_MANUAL;
                    cnt_p0   = '0;
                    cur_p0   = s;
                    y_p0     = man_y;
                    vld_p0   = man_ok;
                end else if (!any_en) begin
                    state_p0 = ST_IDLE;
                    cnt_p0   = '0;
                    y_p0     = '0;
                    vld_p0   = 1'b0;
                end else if (!cur_en || (cnt_p1 == DWELL_LAST)) begin
                    // Dwell finished, or the current channel was masked off
                    // mid-dwell: move on and give the new channel a full dwell.
                    cnt_p0  = '0;
                    cur_p0  = nxt_idx;
                    y_p0    = nxt_data;
                    vld_p0  = 1'b1;
                    wrap_p0 = (nxt_idx <= cur_p1);
                end else begin
                    // Same channel, but data refreshes every cycle.
                    cnt_p0 = cnt_p1 + 1'b1;
                    y_p0   = cur_data;
                    vld_p0 = 1'b1;
                end
            end

            // MANUAL and SCAN_IDLE react to inputs identically; the
            // default also recovers the unused encoding into manual mode.
            default: begin
                if (!mode) begin
                    state_p0 = ST_MANUAL;
                    cnt_p0   = '0;
                    cur_p0   = s;
                    y_p0     = man_y;
                    vld_p0   = man_ok;
                end else if (any_en) begin
                    state_p0 = ST_SCAN;
                    cnt_p0   = '0;
                    cur_p0   = low_idx;
                    y_p0     = low_data;
                    vld_p0   = 1'b1;
                end else begin
                    // Nothing to scan: cur holds, output parked at zero.
                    state_p0 = ST_IDLE;
                    cnt_p0   = '0;
                    y_p0     = '0;
                    vld_p0   = 1'b0;
                end
            end
        endcase
    end

    // p1: output register; reset clears data as well as control so y reads
    // zero straight out of reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_p1 <= ST_MANUAL;
            cnt_p1   <= '0;
            y_p1     <= '0;
            cur_p1   <= '0;
            vld_p1   <= 1'b0;
            wrap_p1  <= 1'b0;
        end else begin
            state_p1 <= state_p0;
            cnt_p1   <= cnt_p0;
            y_p1     <= y_p0;
            cur_p1   <= cur_p0;
            vld_p1   <= vld_p0;
            wrap_p1  <= wrap_p0;
        end
    end

    assign y     = y_p1;
    assign cur   = cur_p1;
    assign valid = vld_p1;
    assign wrap  = wrap_p1;

endmodule

// File: tb/tb_mux_scan.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// tb_mux_scan
//
// Directed bench for mux_scan with N=5, W=8, DWELL=4 and channel data
// {44, 33, 22, 11, 00}. Reset and manual selection run from a vector table;
// the scan sequences are written out as loops with hand-derived expectations.
// -----------------------------------------------------------------------------
module tb_mux_scan;

    localparam int N     = 5;
    localparam int W     = 8;
    localparam int DWELL = 4;
    localparam int SW    = 3;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [N*W-1:0]   d;
    logic [SW-1:0]    s;
    logic             mode;
    logic [N-1:0]     en_mask;
    logic [W-1:0]     y;
    logic [SW-1:0]    cur;
    logic             valid;
    logic             wrap;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux_scan #(
        .N     (N),
        .W     (W),
        .DWELL (DWELL)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (d),
        .s       (s),
        .mode    (mode),
        .en_mask (en_mask),
        .y       (y),
        .cur     (cur),
        .valid   (valid),
        .wrap    (wrap)
    );

    typedef struct {
        logic        rst_n;
        logic        mode;
        logic [2:0]  s;
        logic [4:0]  mask;
        logic [7:0]  y;
        logic [2:0]  cur;
        logic        vld;
        logic        wrp;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [7:0] ey, input logic [2:0] ec,
                              input logic ev, input logic ew);
        chk({tag, "_y"},     y,         ey);
        chk({tag, "_cur"},   8'(cur),   8'(ec));
        chk({tag, "_valid"}, 8'(valid), 8'(ev));
        chk({tag, "_wrap"},  8'(wrap),  8'(ew));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int ec;

        //            rst   mode  s     mask       y      cur   vld   wrp
        tbl[0]  = '{1'b0, 1'b1, 3'd0, 5'b11111, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 3'd0, 5'b11111, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 3'd0, 5'b11111, 8'h00, 3'd0, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 3'd1, 5'b11111, 8'h11, 3'd1, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 3'd2, 5'b11111, 8'h22, 3'd2, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 3'd3, 5'b11111, 8'h33, 3'd3, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 3'd4, 5'b11111, 8'h44, 3'd4, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 3'd5, 5'b11111, 8'h00, 3'd5, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 3'd6, 5'b11111, 8'h00, 3'd6, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 3'd7, 5'b11111, 8'h00, 3'd7, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 3'd2, 5'b11011, 8'h00, 3'd2, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 3'd3, 5'b11011, 8'h33, 3'd3, 1'b1, 1'b0};

        d       = 40'h44_33_22_11_00;
        reset_n = 1'b0;
        mode    = 1'b1;
        s       = 3'd0;
        en_mask = 5'b11111;

        // Reset and manual selection
        for (int i = 0; i < 12; i++) begin
            reset_n = tbl[i].rst_n;
            mode    = tbl[i].mode;
            s       = tbl[i].s;
            en_mask = tbl[i].mask;
            tick();
            expect_out($sformatf("vec%0d", i), tbl[i].y, tbl[i].cur, tbl[i].vld, tbl[i].wrp);
        end

        // Full scan: each channel held 4 edges, wrap on every 4->0 edge
        mode    = 1'b1;
        en_mask = 5'b11111;
        for (int e = 0; e <= 40; e++) begin
            tick();
            ec = (e / 4) % 5;
            expect_out($sformatf("scan%0d", e), 8'(ec * 17), 3'(ec), 1'b1,
                       (e > 0) && (e % 20 == 0));
        end

        // Masked scan 10010: channel 0 is masked at count 0, so the first
        // edge jumps to 1; then 1 and 4 alternate with wrap on each 4->1
        en_mask = 5'b10010;
        for (int m = 0; m <= 25; m++) begin
            tick();
            ec = ((m / 4) % 2 == 0) ? 1 : 4;
            expect_out($sformatf("mask%0d", m), 8'(ec * 17), 3'(ec), 1'b1,
                       (m > 0) && (m % 8 == 0));
        end

        // Drop channel 1 at dwell count 1: jump to 4, which then gets a full
        // dwell and wraps onto itself
        en_mask = 5'b10000;
        for (int k = 0; k <= 4; k++) begin
            tick();
            expect_out($sformatf("drop%0d", k), 8'h44, 3'd4, 1'b1, k == 4);
        end

        // Empty mask: idle, cur holds
        en_mask = 5'b00000;
        for (int k = 0; k < 3; k++) begin
            tick();
            expect_out($sformatf("idle%0d", k), 8'h00, 3'd4, 1'b0, 1'b0);
        end

        // Mask returns with only channel 2: scan resumes there
        en_mask = 5'b00100;
        for (int k = 0; k <= 4; k++) begin
            tick();
            expect_out($sformatf("solo%0d", k), 8'h22, 3'd2, 1'b1, k == 4);
        end

        // Manual, then scan to dwell count 2, then back to manual s=3
        en_mask = 5'b11111;
        mode    = 1'b0;
        s       = 3'd0;
        tick();
        expect_out("man0", 8'h00, 3'd0, 1'b1, 1'b0);
        mode = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            expect_out($sformatf("pre%0d", k), 8'h00, 3'd0, 1'b1, 1'b0);
        end
        mode = 1'b0;
        s    = 3'd3;
        tick();
        expect_out("man3", 8'h33, 3'd3, 1'b1, 1'b0);

        // Back to scan with mask 11110: lowest is 1, with a fresh dwell count
        mode    = 1'b1;
        en_mask = 5'b11110;
        for (int k = 0; k <= 4; k++) begin
            tick();
            ec = (k < 4) ? 1 : 2;
            expect_out($sformatf("restart%0d", k), 8'(ec * 17), 3'(ec), 1'b1, 1'b0);
        end

        // Reset mid-scan clears everything on that edge
        reset_n = 1'b0;
        tick();
        expect_out("rstmid", 8'h00, 3'd0, 1'b0, 1'b0);

        // First edge after release is decided from manual state
        reset_n = 1'b1;
        tick();
        expect_out("postrst", 8'h11, 3'd1, 1'b1, 1'b0);

        reset_n = 1'b0;
        tick();
        expect_out("rst2", 8'h00, 3'd0, 1'b0, 1'b0);
        reset_n = 1'b1;
        mode    = 1'b0;
        s       = 3'd4;
        tick();
        expect_out("postrst_man", 8'h44, 3'd4, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
